instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/arm_isa_pkg.sv | 37 +++
 rtl/instr_field_pack.sv | 37 +++
 rtl/instr_encoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/arm_isa_pkg.sv
// ============================================================================
// Module : arm_isa_pkg
// Brief  : Shared ARM-style encoding constants, request kinds and FSM states
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package arm_isa_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef enum logic [2:0] {
    KIND_DP_REG = 3'd0,
    KIND_DP_IMM = 3'd1,
    KIND_STR    = 3'd2,
    KIND_LDR    = 3'd3,
    KIND_B      = 3'd4
  } kind_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_AL = 4'hE;

  // MOV r0, r0 with the always condition
  localparam logic [31:0] NOP_WORD = 32'hE1A00000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/instr_field_pack.sv
// ============================================================================
// Module : instr_field_pack
// Brief  : Combinational packing of request fields into a 32-bit instruction
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_field_pack
  import arm_isa_pkg::*;
(
  input  logic [2:0]  in_kind,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_cmd,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rm,
  input  logic        in_s,
  input  logic [23:0] in_imm,
  output logic [31:0] word
);

  always_comb begin
    word = NOP_WORD;
    case (in_kind)
      KIND_DP_REG: word = {in_cond, OP_DP, 1'b0, in_cmd, in_s, in_rn, in_rd, 8'h00, in_rm};
      KIND_DP_IMM: word = {in_cond, OP_DP, 1'b1, in_cmd, in_s, in_rn, in_rd, in_imm[11:0]};
      // immediate offset, pre-index, add, word access, no writeback
      KIND_STR:    word = {in_cond, OP_MEM, 5'b01100, 1'b0, in_rn, in_rd, in_imm[11:0]};
      KIND_LDR:    word = {in_cond, OP_MEM, 5'b01100, 1'b1, in_rn, in_rd, in_imm[11:0]};
      KIND_B:      word = {in_cond, OP_BR, 2'b10, in_imm};
      default:     word = NOP_WORD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module : instr_encoder
// Brief  : Encodes instruction requests and writes them sequentially into
//          instruction memory. Optional INSTR_ENCODER_CHECK_EN rejects illegal
//          kinds with an err pulse instead of writing a NOP.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_encoder
  import arm_isa_pkg::*;
#(
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_cmd,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rm,
  input  logic              in_s,
  input  logic [23:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              full,
  output logic              err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         w_word;
  logic                w_legal;
  logic                w_accept;
  logic                w_write;

  instr_field_pack u_pack (
    .in_kind (in_kind),
    .in_cond (in_cond),
    .in_cmd  (in_cmd),
    .in_rn   (in_rn),
    .in_rd   (in_rd),
    .in_rm   (in_rm),
    .in_s    (in_s),
    .in_imm  (in_imm),
    .word    (w_word)
  );

`ifdef INSTR_ENCODER_CHECK_EN
  assign w_legal = (in_kind <= KIND_B);
`else
  assign w_legal = 1'b1;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_write  = w_accept && w_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    // A write already on the port this cycle finishes; only the count rewinds.
    if (restart) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_write) begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = w_word;
          end
        end
        ST_WRITE: begin
          if (addr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_IDLE;
            addr_d  = addr_q + ADDR_W'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    in_ready   = (state_q == ST_IDLE) && !restart && !rst;
    full       = (state_q == ST_FULL);
    imem_we    = we_q;
    imem_addr  = waddr_q;
    imem_wdata = wdata_q;
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic err_q, err_d;

  assign err_d = w_accept && !w_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire
